wb_timeout_bridge: RTL
======================

# wb_timeout_bridge

Registered Wishbone bridge between the neorv32 external bus master and the `wb_xbar` slave side. It forwards each CPU request to the crossbar and holds it until the addressed slave acknowledges. If no slave answers within a bounded number of cycles, it terminates the transfer itself with an error response, so an unmapped or hung peripheral cannot stall the CPU. It also records timeout statistics for debug.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: number of cycles the downstream request is held before the bridge aborts it. Legal range 2..65535.
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on a timed-out transfer.

Ports:
- `clk`  in  1  system clock; every flop is on the rising edge.
- `arstn`  in  1  asynchronous active-low reset.
- `wb_adr_i`  in  32  upstream address.
- `wb_dat_i`  in  32  upstream write data.
- `wb_dat_o`  out  32  upstream read data, registered.
- `wb_we_i`  in  1  upstream write enable.
- `wb_sel_i`  in  4  upstream byte selects.
- `wb_stb_i`  in  1  upstream strobe.
- `wb_cyc_i`  in  1  upstream cycle.
- `wb_ack_o`  out  1  upstream acknowledge, registered, one-cycle pulse.
- `wb_err_o`  out  1  upstream error; high only together with `wb_ack_o` on a timed-out transfer.
- `m_adr_o`, `m_dat_o`, `m_we_o`, `m_sel_o`  out  32/32/1/4  downstream request fields, registered.
- `m_stb_o`, `m_cyc_o`  out  1  downstream strobe and cycle, registered.
- `m_dat_i`  in  32  downstream read data.
- `m_ack_i`  in  1  downstream acknowledge.
- `timeout_clr_i`  in  1  synchronous clear of the statistics.
- `timeout_cnt_o`  out  8  saturating count of timeouts.
- `last_err_adr_o`  out  32  address of the most recent timed-out transfer.
- `timeout_irq_o`  out  1  one-cycle pulse on each timeout.

## Operation

- The FSM has three states: IDLE, REQ and RESP. The reset state is IDLE.
- IDLE:
  - When `wb_cyc_i & wb_stb_i` is high, capture adr, dat, we and sel into the `m_*` registers.
  - Set `m_cyc_o` = `m_stb_o` = 1, clear the wait counter, and go to REQ.
- REQ:
  - `m_*` outputs stay stable and `m_cyc_o`/`m_stb_o` stay high.
  - If `m_ack_i` = 1: latch `m_dat_i` into `wb_dat_o` (for writes too), drop `m_cyc_o`/`m_stb_o`, set `wb_ack_o` = 1 and `wb_err_o` = 0, and go to RESP.
  - Otherwise, if the wait counter equals `TIMEOUT_CYCLES`-1: `wb_dat_o` ← `ERR_DATA`, `wb_ack_o` = `wb_err_o` = 1, pulse `timeout_irq_o`, `last_err_adr_o` ← `m_adr_o`, increment `timeout_cnt_o` (saturating at 255), drop the downstream request, and go to RESP.
  - Otherwise, increment the wait counter (16 bits).
  - If `m_ack_i` and the timeout condition occur in the same cycle, the ack wins: normal response, no error, and no statistics update.
  - If `wb_cyc_i` = 0 in REQ (upstream abort): drop the downstream request and go to IDLE. No ack, no error, no statistics update. An `m_ack_i` in that same cycle is ignored.
- RESP:
  - `wb_ack_o` and `wb_err_o` are high for exactly this one cycle, then clear.
  - Always return to IDLE. A request present during RESP is not accepted; it is sampled again in IDLE.
- `m_ack_i` is ignored in IDLE and RESP.
- `timeout_clr_i`: zeroes `timeout_cnt_o` and `last_err_adr_o`. If it coincides with a timeout, the counter ends at 1 and the address is captured.

## Timing

- Reset values: `wb_dat_o` = 0, `wb_ack_o` = 0, `wb_err_o` = 0, all `m_*` outputs = 0, `timeout_cnt_o` = 0, `last_err_adr_o` = 0, `timeout_irq_o` = 0, state = IDLE, wait counter = 0.
- `arstn` asserted mid-transfer: all outputs return immediately to their reset values. The downstream request is dropped without waiting for an ack.
- Request in cycle 0 → `m_stb_o` high from cycle 1.
- Slave ack in cycle k ≥ 1 → `wb_ack_o` high in cycle k+1. Minimum round trip is 2 cycles.
- Timeout: `m_stb_o` is high for exactly `TIMEOUT_CYCLES` cycles (cycles 1..T). `wb_ack_o`, `wb_err_o` and `timeout_irq_o` are high in cycle T+1.
- Back-to-back transfers: the next request is accepted no earlier than the cycle after RESP. Steady-state throughput is 1 transfer per 3 cycles with zero-wait slaves.

## Test plan

- **Zero-wait read:** read 0x9000_0004; slave acks in cycle 1 with 0x1234_5678 → `wb_ack_o` in cycle 2, `wb_dat_o` = 0x1234_5678, `wb_err_o` = 0.
- **Wait-state write:** write 0xCAFE_0001 with sel = 4'b0011; slave acks in cycle 5 → `m_dat_o`/`m_sel_o` stable for cycles 1–5, `wb_ack_o` in cycle 6, `m_stb_o` low in cycle 6.
- **Timeout:** `TIMEOUT_CYCLES` = 8, read 0xF000_0000, no slave ack → `m_stb_o` high for cycles 1–8; cycle 9 shows `wb_ack_o` = `wb_err_o` = 1, `wb_dat_o` = 0xDEAD_BEEF, `timeout_irq_o` pulse, `timeout_cnt_o` = 1, `last_err_adr_o` = 0xF000_0000.
- **Ack/timeout race:** `TIMEOUT_CYCLES` = 8, slave acks in cycle 8 → normal ack in cycle 9, `wb_err_o` = 0, `timeout_cnt_o` unchanged.
- **Saturation and clear:** 300 consecutive timeouts → `timeout_cnt_o` = 255; `timeout_clr_i` asserted in the same cycle as the next timeout → `timeout_cnt_o` = 1.
- **Abort and reset:** drop `wb_cyc_i` in cycle 3 of a pending transfer → `m_cyc_o` = 0 in cycle 4, no `wb_ack_o`. Assert `arstn` low mid-REQ → all outputs 0 asynchronously; the next request after reset completes normally.

Source files
------------

// File: rtl/wb_timeout_bridge.sv
// wb_timeout_bridge
// Registered Wishbone bridge from the CPU external bus to the crossbar slave
// side. Each request is forwarded and held until the slave acknowledges. If the
// slave stays silent for TIMEOUT_CYCLES cycles, the bridge answers the CPU with
// an error response so the core cannot hang on an unmapped address. Timeout
// statistics (saturating count, last failing address, pulse) are kept for debug.

module wb_timeout_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        arstn,

    // upstream (CPU) side
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,

    // downstream (crossbar) side
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,

    // debug statistics
    input  logic        timeout_clr_i,
    output logic [7:0]  timeout_cnt_o,
    output logic [31:0] last_err_adr_o,
    output logic        timeout_irq_o
);

    localparam int unsigned DATA_W    = 32;
    // Wait counter value seen in the last cycle the request may stay open.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("wb_timeout_bridge: TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Saturating +1 for the 8-bit timeout counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    state_t             state, state_d;
    logic [15:0]        wait_cnt, wait_cnt_d;

    logic [DATA_W-1:0]  req_adr, req_adr_d;
    logic [DATA_W-1:0]  req_dat, req_dat_d;
    logic               req_we, req_we_d;
    logic [3:0]         req_sel, req_sel_d;
    logic               req_vld, req_vld_d;

    logic [DATA_W-1:0]  rsp_dat, rsp_dat_d;
    logic               rsp_ack, rsp_ack_d;
    logic               rsp_err, rsp_err_d;

    logic [7:0]         tmo_cnt, tmo_cnt_d, tmo_cnt_base;
    logic [DATA_W-1:0]  tmo_adr, tmo_adr_d, tmo_adr_base;
    logic               tmo_irq, tmo_irq_d;

    // Next-state and next-register logic: accept, wait/ack/timeout/abort, respond.
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        req_adr_d  = req_adr;
        req_dat_d  = req_dat;
        req_we_d   = req_we;
        req_sel_d  = req_sel;
        req_vld_d  = req_vld;
        rsp_dat_d  = rsp_dat;
        rsp_ack_d  = 1'b0;
        rsp_err_d  = 1'b0;
        tmo_irq_d  = 1'b0;

        // A clear takes effect first, so a coincident timeout still counts as 1.
        tmo_cnt_base = timeout_clr_i ? 8'd0 : tmo_cnt;
        tmo_adr_base = timeout_clr_i ? '0 : tmo_adr;
        tmo_cnt_d    = tmo_cnt_base;
        tmo_adr_d    = tmo_adr_base;

        case (state)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    req_adr_d  = wb_adr_i;
                    req_dat_d  = wb_dat_i;
                    req_we_d   = wb_we_i;
                    req_sel_d  = wb_sel_i;
                    req_vld_d  = 1'b1;
                    wait_cnt_d = 16'd0;
                    state_d    = S_REQ;
                end
            end

            S_REQ: begin
                if (!wb_cyc_i) begin
                    // Master gave up: withdraw silently, any ack this cycle is dropped.
                    req_vld_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (m_ack_i) begin
                    // Ack beats a timeout landing in the same cycle.
                    rsp_dat_d = m_dat_i;
                    rsp_ack_d = 1'b1;
                    req_vld_d = 1'b0;
                    state_d   = S_RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    rsp_dat_d = ERR_DATA;
                    rsp_ack_d = 1'b1;
                    rsp_err_d = 1'b1;
                    tmo_irq_d = 1'b1;
                    tmo_adr_d = req_adr;
                    tmo_cnt_d = sat_inc8(tmo_cnt_base);
                    req_vld_d = 1'b0;
                    state_d   = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt + 16'd1;
                end
            end

            S_RESP: begin
                // Response is visible for this single cycle; a pending request
                // is only sampled again once back in idle.
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                req_vld_d = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Request, response, wait counter and statistics registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wait_cnt <= 16'd0;
            req_adr  <= '0;
            req_dat  <= '0;
            req_we   <= 1'b0;
            req_sel  <= 4'd0;
            req_vld  <= 1'b0;
            rsp_dat  <= '0;
            rsp_ack  <= 1'b0;
            rsp_err  <= 1'b0;
            tmo_cnt  <= 8'd0;
            tmo_adr  <= '0;
            tmo_irq  <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_d;
            req_adr  <= req_adr_d;
            req_dat  <= req_dat_d;
            req_we   <= req_we_d;
            req_sel  <= req_sel_d;
            req_vld  <= req_vld_d;
            rsp_dat  <= rsp_dat_d;
            rsp_ack  <= rsp_ack_d;
            rsp_err  <= rsp_err_d;
            tmo_cnt  <= tmo_cnt_d;
            tmo_adr  <= tmo_adr_d;
            tmo_irq  <= tmo_irq_d;
        end
    end

    assign m_adr_o        = req_adr;
    assign m_dat_o        = req_dat;
    assign m_we_o         = req_we;
    assign m_sel_o        = req_sel;
    assign m_stb_o        = req_vld;
    assign m_cyc_o        = req_vld;

    assign wb_dat_o       = rsp_dat;
    assign wb_ack_o       = rsp_ack;
    assign wb_err_o       = rsp_err;

    assign timeout_cnt_o  = tmo_cnt;
    assign last_err_adr_o = tmo_adr;
    assign timeout_irq_o  = tmo_irq;

endmodule
